// File: rtl/rs_gf_pkg.sv
// Shared GF(2^M) helpers and types for the RS decoder Chien search.
// Contents:
//   GF_M, GF_PRIM_POLY   default field width and generator polynomial
//   gf_mul(a, b)         polynomial-basis multiply; shift-and-reduce over GF(2^m)
//   gf_alpha_pow(e)      alpha^e, meant for elaboration-time constants
//   gf_short_j0(m, n)    first scanned exponent of a shortened code, 2^m - n
//   chien_state_t        Chien search FSM states
// The helpers take the field width and polynomial as defaulted arguments so that
// a non-default M can reuse them. Width is capped at GF_MAX_M bits.
package rs_gf_pkg;

  localparam int unsigned GF_M         = 8;
  localparam logic [8:0]  GF_PRIM_POLY = 9'h11D;
  localparam int unsigned GF_MAX_M     = 16;

  localparam logic [GF_MAX_M:0] GfPolyDefault = (GF_MAX_M + 1)'(GF_PRIM_POLY);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FIN
  } chien_state_t;

  // MSB-first multiply. With one operand constant this folds into an XOR network.
  function automatic logic [GF_MAX_M-1:0] gf_mul(
      input logic [GF_MAX_M-1:0] a,
      input logic [GF_MAX_M-1:0] b,
      input int unsigned         m    = GF_M,
      input logic [GF_MAX_M:0]   poly = GfPolyDefault);
    logic [GF_MAX_M:0] acc;
    acc = '0;
    for (int i = GF_MAX_M - 1; i >= 0; i--) begin
      if (i < int'(m)) begin
        acc = acc << 1;
        if (acc[m]) acc = acc ^ poly;
        if (b[i]) acc = acc ^ {1'b0, a};
      end
    end
    return acc[GF_MAX_M-1:0];
  endfunction

  function automatic logic [GF_MAX_M-1:0] gf_alpha_pow(
      input int unsigned       e,
      input int unsigned       m    = GF_M,
      input logic [GF_MAX_M:0] poly = GfPolyDefault);
    logic [GF_MAX_M:0] acc;
    int unsigned       n;
    n      = e % ((32'd1 << m) - 32'd1);
    acc    = '0;
    acc[0] = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      acc = acc << 1;
      if (acc[m]) acc = acc ^ poly;
    end
    return acc[GF_MAX_M-1:0];
  endfunction

  // Position L of a shortened code is located at x = alpha^(j0 + (n-1-L)).
  function automatic int unsigned gf_short_j0(input int unsigned m, input int unsigned n_code);
    return (32'd1 << m) - n_code;
  endfunction

endpackage

// File: rtl/chien_cell.sv
// One Chien search term register: holds sigma_K * alpha^(K*j) for the current
// evaluation exponent j.
// Ports:
//   clk_i     clock
//   reset_ni  synchronous, active-low reset (clears the register)
//   load_i    load sigma_i * alpha^INIT_EXP
//   step_i    advance: register * alpha^K
//   sigma_i   locator coefficient sigma_K
//   term_o    current term value
module chien_cell
  import rs_gf_pkg::*;
#(
  parameter int unsigned M         = GF_M,
  parameter int unsigned K         = 1,
  parameter int unsigned INIT_EXP  = 0,
  parameter logic [M:0]  PRIM_POLY = (M + 1)'(GF_PRIM_POLY)
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [M-1:0] sigma_i,
  output logic [M-1:0] term_o
);

  localparam logic [GF_MAX_M:0]   PolyExt   = (GF_MAX_M + 1)'(PRIM_POLY);
  localparam logic [GF_MAX_M-1:0] LoadConst = gf_alpha_pow(INIT_EXP, M, PolyExt);
  localparam logic [GF_MAX_M-1:0] StepConst = gf_alpha_pow(K, M, PolyExt);

  logic [M-1:0] cell_d, cell_q;

  always_comb begin
    cell_d = cell_q;
    if (load_i) begin
      cell_d = M'(gf_mul(GF_MAX_M'(sigma_i), LoadConst, M, PolyExt));
    end else if (step_i) begin
      cell_d = M'(gf_mul(GF_MAX_M'(cell_q), StepConst, M, PolyExt));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cell_q <= '0;
    end else begin
      cell_q <= cell_d;
    end
  end

  assign term_o = cell_q;

endmodule

// File: rtl/rs_chien_search.sv
// Chien search for the RS decoder error-location stage (default DVB-T RS(204,188), t=8).
// Scans only the N_CODE positions of the shortened code, highest position first.
// Ports:
//   Clk, Reset   clock; synchronous active-low reset
//   Start        load Sigma/Degree; accepted only in IDLE
//   Sigma        sigma_k at [k*M-1 -: M], k=1..T (sigma_0 = 1 implied)
//   Degree       locator degree from Berlekamp-Massey
//   Busy         high while scanning
//   Done         one-cycle pulse, results valid
//   Locations    slot s at [(s+1)*M-1 -: M], positions in descending order
//   LocValid     bit s set when slot s holds a root
//   NumRoots     roots found
//   Fail         NumRoots != Degree, Degree > T, or more than T roots
// Optional build macro CHIEN_ROOT_STREAM_EN adds ErrStrobe/ErrPos/ErrHit, a per-position
// combinational stream of root flags for a pipelined Forney unit.
module rs_chien_search
  import rs_gf_pkg::*;
#(
  parameter int unsigned M         = GF_M,
  parameter int unsigned T         = 8,
  parameter int unsigned N_CODE    = 204,
  parameter logic [M:0]  PRIM_POLY = (M + 1)'(GF_PRIM_POLY),
  localparam int unsigned DW       = $clog2(T + 1)
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [T*M-1:0] Sigma,
  input  logic [DW-1:0]  Degree,
  output logic           Busy,
  output logic           Done,
  output logic [T*M-1:0] Locations,
  output logic [T-1:0]   LocValid,
  output logic [DW-1:0]  NumRoots,
  output logic           Fail
`ifdef CHIEN_ROOT_STREAM_EN
  ,
  output logic           ErrStrobe,
  output logic [M-1:0]   ErrPos,
  output logic           ErrHit
`endif
);

  localparam int unsigned J0     = gf_short_j0(M, N_CODE);
  localparam int unsigned FieldN = (32'd1 << M) - 32'd1;

  chien_state_t   state_d, state_q;
  logic [M-1:0]   pos_d, pos_q;          // position L under evaluation
  logic [DW-1:0]  degree_d, degree_q;
  logic [T*M-1:0] locations_d, locations_q;
  logic [T-1:0]   loc_valid_d, loc_valid_q;
  logic [DW-1:0]  num_roots_d, num_roots_q;
  logic           overflow_d, overflow_q;
  logic           fail_d, fail_q;
  logic           done_d, done_q;

  logic           cell_load, cell_step;
  logic [M-1:0]   term [T];
  logic [M-1:0]   eval_sum;
  logic           is_root;

  for (genvar k = 0; k < T; k++) begin : g_cell
    chien_cell #(
      .M        (M),
      .K        (k + 1),
      .INIT_EXP (((k + 1) * J0) % FieldN),
      .PRIM_POLY(PRIM_POLY)
    ) u_cell (
      .clk_i   (Clk),
      .reset_ni(Reset),
      .load_i  (cell_load),
      .step_i  (cell_step),
      .sigma_i (Sigma[k*M +: M]),
      .term_o  (term[k])
    );
  end

  // sigma(x) = 1 + sum of cell terms; a zero sum marks a root.
  always_comb begin
    eval_sum = M'(1);
    for (int k = 0; k < T; k++) begin
      eval_sum = eval_sum ^ term[k];
    end
    is_root = (state_q == SCAN) && (eval_sum == '0);
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    degree_d    = degree_q;
    locations_d = locations_q;
    loc_valid_d = loc_valid_q;
    num_roots_d = num_roots_q;
    overflow_d  = overflow_q;
    fail_d      = fail_q;
    done_d      = 1'b0;
    cell_load   = 1'b0;
    cell_step   = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d     = SCAN;
          cell_load   = 1'b1;
          pos_d       = M'(N_CODE - 1);
          degree_d    = Degree;
          locations_d = '0;
          loc_valid_d = '0;
          num_roots_d = '0;
          overflow_d  = 1'b0;
          fail_d      = 1'b0;
        end
      end
      SCAN: begin
        cell_step = 1'b1;
        if (is_root) begin
          if (num_roots_q == DW'(T)) begin
            overflow_d = 1'b1;
          end else begin
            for (int s = 0; s < T; s++) begin
              if (DW'(s) == num_roots_q) begin
                locations_d[s*M +: M] = pos_q;
                loc_valid_d[s]        = 1'b1;
              end
            end
            num_roots_d = num_roots_q + DW'(1);
          end
        end
        if (pos_q == '0) begin
          state_d = FIN;
          done_d  = 1'b1;
          // Uses the _d values so a root on the final position is included.
          fail_d  = overflow_d || (num_roots_d != degree_q) || (degree_q > DW'(T));
        end else begin
          pos_d = pos_q - M'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      degree_q    <= '0;
      locations_q <= '0;
      loc_valid_q <= '0;
      num_roots_q <= '0;
      overflow_q  <= 1'b0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      degree_q    <= degree_d;
      locations_q <= locations_d;
      loc_valid_q <= loc_valid_d;
      num_roots_q <= num_roots_d;
      overflow_q  <= overflow_d;
      fail_q      <= fail_d;
      done_q      <= done_d;
    end
  end

  assign Busy      = (state_q == SCAN);
  assign Done      = done_q;
  assign Locations = locations_q;
  assign LocValid  = loc_valid_q;
  assign NumRoots  = num_roots_q;
  assign Fail      = fail_q;

`ifdef CHIEN_ROOT_STREAM_EN
  // Gated by Reset so the stream is silent during the reset cycle itself.
  always_comb begin
    ErrStrobe = Reset && (state_q == SCAN);
    ErrPos    = ErrStrobe ? pos_q : '0;
    ErrHit    = Reset && is_root;
  end
`endif

endmodule

// File: tb/tb_rs_chien_search.sv
// Directed bench for rs_chien_search (default parameters: GF(256), T=8, N_CODE=204).
module tb_rs_chien_search;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [63:0] Sigma;
  logic [3:0]  Degree;
  logic        Busy;
  logic        Done;
  logic [63:0] Locations;
  logic [7:0]  LocValid;
  logic [3:0]  NumRoots;
  logic        Fail;
`ifdef CHIEN_ROOT_STREAM_EN
  logic        ErrStrobe;
  logic [7:0]  ErrPos;
  logic        ErrHit;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  rs_chien_search dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Sigma    (Sigma),
    .Degree   (Degree),
    .Busy     (Busy),
    .Done     (Done),
    .Locations(Locations),
    .LocValid (LocValid),
    .NumRoots (NumRoots),
    .Fail     (Fail)
`ifdef CHIEN_ROOT_STREAM_EN
    ,
    .ErrStrobe(ErrStrobe),
    .ErrPos   (ErrPos),
    .ErrHit   (ErrHit)
`endif
  );

`ifdef CHIEN_ROOT_STREAM_EN
  int strobes = 0;
  int hits    = 0;
  int stray   = 0;
  int hit_pos [$];
  always @(posedge Clk) begin
    #1;
    if (ErrStrobe) strobes++;
    if (ErrHit) begin
      hits++;
      hit_pos.push_back(int'(ErrPos));
      if (!ErrStrobe) stray++;
    end
  end
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent GF(256) model, LSB-first multiply, poly 0x11D.
  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] alpha(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e % 255; i++) r = mul(r, 8'h02);
    return r;
  endfunction

  // sigma(x) = prod (1 + alpha^L x) over the given positions.
  function automatic logic [63:0] build_sigma(input int pos [8], input int n);
    logic [7:0]  c [9];
    logic [63:0] s;
    for (int k = 0; k < 9; k++) c[k] = 8'h00;
    c[0] = 8'h01;
    for (int r = 0; r < n; r++) begin
      for (int k = 8; k >= 1; k--) c[k] = c[k] ^ mul(alpha(pos[r]), c[k-1]);
    end
    s = '0;
    for (int k = 1; k <= 8; k++) s[(k-1)*8 +: 8] = c[k];
    return s;
  endfunction

  // Launch a scan and wait for Done; lat = edges after the accepting edge.
  // A second Start (with scrambled inputs) is driven at cycle repulse_at, if >= 0.
  task automatic run_scan(input logic [63:0] sig, input logic [3:0] deg, input int repulse_at,
                          input string tag);
    int lat;
    Sigma  = sig;
    Degree = deg;
    Start  = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    chk({tag, "_busy"}, Busy, 1);
    lat = 0;
    while (!Done && lat < 400) begin
      @(posedge Clk);
      #1;
      lat++;
      if (lat == repulse_at) begin
        Start  = 1'b1;
        Sigma  = '0;
        Degree = 4'd0;
      end else begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    chk({tag, "_latency"}, lat, 204);
    chk({tag, "_busy_at_done"}, Busy, 0);
  endtask

  task automatic check_results(input string tag, input logic [63:0] loc, input logic [7:0] lv,
                               input logic [3:0] nr, input logic fl);
    chk({tag, "_locations"}, Locations, loc);
    chk({tag, "_locvalid"}, LocValid, lv);
    chk({tag, "_numroots"}, NumRoots, nr);
    chk({tag, "_fail"}, Fail, fl);
    @(posedge Clk);
    #1;
    chk({tag, "_done_pulse"}, Done, 0);
    chk({tag, "_hold"}, Locations, loc);
  endtask

  int p_one [8]   = '{10, 0, 0, 0, 0, 0, 0, 0};
  int p_two [8]   = '{203, 0, 0, 0, 0, 0, 0, 0};
  int p_out [8]   = '{230, 0, 0, 0, 0, 0, 0, 0};
  int p_eight [8] = '{3, 17, 50, 88, 120, 160, 190, 201};

  initial begin
    int nd;
`ifdef CHIEN_ROOT_STREAM_EN
    int s0;
    int h0;
`endif
    Reset  = 1'b0;
    Start  = 1'b0;
    Sigma  = '0;
    Degree = 4'd0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_locations", Locations, 0);
    chk("rst_locvalid", LocValid, 0);
    chk("rst_numroots", NumRoots, 0);
    chk("rst_fail", Fail, 0);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // Single root at position 10, sigma_1 = alpha^10 = 0x74.
    run_scan(64'h74, 4'd1, -1, "t1");
    check_results("t1", 64'h0A, 8'h01, 4'd1, 1'b0);

    // Roots at 203 (first scanned) and 0 (last scanned).
`ifdef CHIEN_ROOT_STREAM_EN
    s0 = strobes;
    h0 = hits;
`endif
    run_scan(build_sigma(p_two, 2), 4'd2, -1, "t2");
`ifdef CHIEN_ROOT_STREAM_EN
    chk("t6_strobes", strobes - s0, 204);
    chk("t6_hits", hits - h0, 2);
    if (hit_pos.size() >= h0 + 2) begin
      chk("t6_hit0_pos", hit_pos[h0], 203);
      chk("t6_hit1_pos", hit_pos[h0+1], 0);
    end else begin
      chk("t6_hit_queue", hit_pos.size(), h0 + 2);
    end
    chk("t6_stray_hits", stray, 0);
`endif
    check_results("t2", 64'h00CB, 8'h03, 4'd2, 1'b0);

    // Root at position 230 lies beyond the shortened code.
    run_scan(build_sigma(p_out, 1), 4'd1, -1, "t3");
    check_results("t3", 64'h0, 8'h00, 4'd0, 1'b1);

    // Eight roots, reported in descending position order.
    run_scan(build_sigma(p_eight, 8), 4'd8, -1, "t4");
    check_results("t4", 64'h03113258_78A0BEC9, 8'hFF, 4'd8, 1'b0);

    // Empty locator: full scan, nothing found, no failure.
    run_scan(64'h0, 4'd0, -1, "deg0");
    check_results("deg0", 64'h0, 8'h00, 4'd0, 1'b0);

    // Degree above T is uncorrectable regardless of roots.
    run_scan(64'h0, 4'd9, -1, "deg9");
    check_results("deg9", 64'h0, 8'h00, 4'd0, 1'b1);

    // Start re-pulsed mid-scan with different inputs must be ignored.
    run_scan(64'h74, 4'd1, 50, "t5a");
    check_results("t5a", 64'h0A, 8'h01, 4'd1, 1'b0);

    // Reset at cycle 100 of a scan that already found position 203.
    Sigma  = build_sigma(p_two, 2);
    Degree = 4'd2;
    Start  = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (99) @(posedge Clk);
    #1;
    chk("t5b_midscan_numroots", NumRoots, 1);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    chk("t5b_rst_busy", Busy, 0);
    chk("t5b_rst_done", Done, 0);
    chk("t5b_rst_locations", Locations, 0);
    chk("t5b_rst_locvalid", LocValid, 0);
    chk("t5b_rst_numroots", NumRoots, 0);
    chk("t5b_rst_fail", Fail, 0);
`ifdef CHIEN_ROOT_STREAM_EN
    chk("t5b_rst_strobe", ErrStrobe, 0);
`endif
    Reset = 1'b1;
    nd = 0;
    repeat (250) begin
      @(posedge Clk);
      #1;
      if (Done) nd++;
    end
    chk("t5b_no_done", nd, 0);
    run_scan(64'h74, 4'd1, -1, "t5c");
    check_results("t5c", 64'h0A, 8'h01, 4'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
